// File: rtl/ffo_norm_if.sv
// ffo_norm_if: handshake bundle for the find-first-one / normalise unit.
//   in_*  : upstream word (in_valid/in_ready, in_data, in_lsb search direction)
//   out_* : result (out_valid/out_ready, out_v found flag, out_p index,
//           out_shamt shift amount, out_norm normalised word)
// slave  = the unit itself, master = whoever feeds and drains it.
interface ffo_norm_if #(
   parameter int WIDTH = 32
);
   localparam int PW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_lsb;
   logic             out_valid;
   logic             out_ready;
   logic             out_v;
   logic [PW-1:0]    out_p;
   logic [PW-1:0]    out_shamt;
   logic [WIDTH-1:0] out_norm;

   modport slave (
      input  in_valid, in_data, in_lsb, out_ready,
      output in_ready, out_valid, out_v, out_p, out_shamt, out_norm
   );

   modport master (
      output in_valid, in_data, in_lsb, out_ready,
      input  in_ready, out_valid, out_v, out_p, out_shamt, out_norm
   );
endinterface

// File: rtl/ffo_norm_pipe.sv
// ffo_norm_pipe: two-stage find-first-one and normaliser.
//   clk, reset : clock, synchronous active-high reset
//   io         : ffo_norm_if.slave handshake bundle (input word / result)
//   zero_cnt   : saturating count of all-zero words delivered at the output
// S1 registers the word plus per-nibble any-set flags and in-nibble index.
// S2 merges the nibbles in a log2 tree, barrel-shifts, and registers results.

// Per-nibble first-one: highest set bit in MSB mode, lowest in LSB mode.
module ffo_norm_grp (
   input  logic [3:0] nib,
   input  logic       lsb,
   output logic       any,
   output logic [1:0] idx
);
   always_comb begin
      any = |nib;
      idx = 2'd0;
      if (lsb) begin
         if      (nib[0]) idx = 2'd0;
         else if (nib[1]) idx = 2'd1;
         else if (nib[2]) idx = 2'd2;
         else             idx = 2'd3;
      end else begin
         if      (nib[3]) idx = 2'd3;
         else if (nib[2]) idx = 2'd2;
         else if (nib[1]) idx = 2'd1;
         else             idx = 2'd0;
      end
   end
endmodule

module ffo_norm_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   ffo_norm_if.slave        io,
   output logic [CNT_W-1:0] zero_cnt
);
   localparam int PW = $clog2(WIDTH);
   localparam int NG = WIDTH / 4;
   localparam int GW = $clog2(NG);

   // vld_q[1] = S1 holds a word, vld_q[2] = S2 (output) holds a result
   logic [2:1]             vld_q, vld_d;
   logic [WIDTH-1:0]       s1_data_q, s1_data_d;
   logic                   s1_lsb_q, s1_lsb_d;
   logic [NG-1:0]          s1_any_q, s1_any_d;
   logic [NG-1:0][1:0]     s1_idx_q, s1_idx_d;
   logic                   out_v_q, out_v_d;
   logic [PW-1:0]          out_p_q, out_p_d;
   logic [PW-1:0]          out_shamt_q, out_shamt_d;
   logic [WIDTH-1:0]       out_norm_q, out_norm_d;
   logic [CNT_W-1:0]       zero_cnt_q, zero_cnt_d;

   logic [NG-1:0]          grp_any;
   logic [NG-1:0][1:0]     grp_idx;
   logic [NG-1:0]          t_any;
   logic [NG-1:0][PW-1:0]  t_idx;
   logic                   v_c;
   logic [PW-1:0]          p_c, shamt_c;
   logic [WIDTH-1:0]       norm_c;
   logic                   in_xfer, out_xfer, s2_load;

   for (genvar g = 0; g < NG; g++) begin : g_grp
      ffo_norm_grp u_grp (
         .nib (io.in_data[4*g +: 4]),
         .lsb (io.in_lsb),
         .any (grp_any[g]),
         .idx (grp_idx[g])
      );
   end

   // Tree merge, done in place: level l folds pairs (2j, 2j+1) into j.
   // Each slot j is read (as 2j/2j+1) before it is overwritten.
   always_comb begin
      t_any = s1_any_q;
      for (int g = 0; g < NG; g++) t_idx[g] = {GW'(g), s1_idx_q[g]};
      for (int l = 0; l < GW; l++) begin
         for (int j = 0; j < (NG >> (l + 1)); j++) begin
            if (s1_lsb_q ? t_any[2*j] : !t_any[2*j+1]) t_idx[j] = t_idx[2*j];
            else                                        t_idx[j] = t_idx[2*j+1];
            t_any[j] = t_any[2*j] | t_any[2*j+1];
         end
      end
      v_c     = t_any[0];
      p_c     = v_c ? t_idx[0] : '0;
      shamt_c = !v_c ? '0 : (s1_lsb_q ? p_c : PW'(WIDTH - 1) - p_c);
      // an all-zero word shifts to zero regardless of direction
      norm_c  = s1_lsb_q ? (s1_data_q >> shamt_c) : (s1_data_q << shamt_c);
   end

   assign out_xfer    = vld_q[2] & io.out_ready;
   assign s2_load     = vld_q[1] & (~vld_q[2] | out_xfer);
   assign io.in_ready = ~vld_q[1] | s2_load;
   assign in_xfer     = io.in_valid & io.in_ready;

   always_comb begin
      vld_d       = vld_q;
      s1_data_d   = s1_data_q;
      s1_lsb_d    = s1_lsb_q;
      s1_any_d    = s1_any_q;
      s1_idx_d    = s1_idx_q;
      out_v_d     = out_v_q;
      out_p_d     = out_p_q;
      out_shamt_d = out_shamt_q;
      out_norm_d  = out_norm_q;
      zero_cnt_d  = zero_cnt_q;

      if (in_xfer) begin
         vld_d[1]  = 1'b1;
         s1_data_d = io.in_data;
         s1_lsb_d  = io.in_lsb;
         s1_any_d  = grp_any;
         s1_idx_d  = grp_idx;
      end else if (s2_load) begin
         vld_d[1]  = 1'b0;
      end

      if (s2_load) begin
         vld_d[2]    = 1'b1;
         out_v_d     = v_c;
         out_p_d     = p_c;
         out_shamt_d = shamt_c;
         out_norm_d  = norm_c;
      end else if (out_xfer) begin
         vld_d[2]    = 1'b0;
      end

      // counted when the zero result leaves, so discarded words never count
      if (out_xfer && !out_v_q && zero_cnt_q != {CNT_W{1'b1}})
         zero_cnt_d = zero_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q       <= '0;
         s1_data_q   <= '0;
         s1_lsb_q    <= 1'b0;
         s1_any_q    <= '0;
         s1_idx_q    <= '0;
         out_v_q     <= 1'b0;
         out_p_q     <= '0;
         out_shamt_q <= '0;
         out_norm_q  <= '0;
         zero_cnt_q  <= '0;
      end else begin
         vld_q       <= vld_d;
         s1_data_q   <= s1_data_d;
         s1_lsb_q    <= s1_lsb_d;
         s1_any_q    <= s1_any_d;
         s1_idx_q    <= s1_idx_d;
         out_v_q     <= out_v_d;
         out_p_q     <= out_p_d;
         out_shamt_q <= out_shamt_d;
         out_norm_q  <= out_norm_d;
         zero_cnt_q  <= zero_cnt_d;
      end
   end

   assign io.out_valid = vld_q[2];
   assign io.out_v     = out_v_q;
   assign io.out_p     = out_p_q;
   assign io.out_shamt = out_shamt_q;
   assign io.out_norm  = out_norm_q;
   assign zero_cnt     = zero_cnt_q;
endmodule
